// File: rtl/change_dispenser.sv
// change_dispenser: pays out a latched change amount as dimes, then nickels, then
// pennies, one coin per 4-phase req/ack handshake with the hopper. A single counter
// times both the ack-edge watchdog and the idle gap between coins.
module change_dispenser #(
   parameter int AMT_W   = 5,
   parameter int TIMEOUT = 1023,
   parameter int GAP_CYC = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vend,
   input  logic [AMT_W-1:0] change,
   input  logic             coin_ack,
   output logic             dime_req,
   output logic             nickel_req,
   output logic             penny_req,
   output logic             busy,
   output logic             done,
   output logic             fault,
   output logic [AMT_W-1:0] remaining,
   output logic [3:0]       coins_out
);

   localparam int CNT_MAX = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int WW      = AMT_W + 4;   // wide enough to compare against 10 at any AMT_W

   typedef enum logic [2:0] {IDLE, SELECT, REQ, RELEASE, GAP, FAULT} state_t;

   state_t           state, state_nxt;
   logic             vend_q;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             dime_nxt, nickel_nxt, penny_nxt;
   logic             busy_nxt, done_nxt, fault_nxt;
   logic [AMT_W-1:0] rem_nxt;
   logic [3:0]       coins_nxt;

   logic             start, tmo, gap_end;
   logic [WW-1:0]    rem_w;
   logic             pick_dime, pick_nickel, pick_penny;
   logic [AMT_W-1:0] coin_val;

   assign start   = vend & ~vend_q;
   assign tmo     = (cnt == CNT_W'(TIMEOUT - 1));
   assign gap_end = (cnt == CNT_W'(GAP_CYC - 1));

   // Greedy coin choice from what is still owed
   assign rem_w       = WW'(remaining);
   assign pick_dime   = (rem_w >= WW'(10));
   assign pick_nickel = !pick_dime && (rem_w >= WW'(5));
   assign pick_penny  = !pick_dime && !pick_nickel && (remaining != '0);

   // Value of the coin currently being requested; the req registers remember the pick
   assign coin_val = dime_req   ? AMT_W'(10) :
                     nickel_req ? AMT_W'(5)  : AMT_W'(1);

   // State, edge-detect history, timer and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         vend_q     <= 1'b1;   // vend held high through reset must not look like an edge
         cnt        <= '0;
         dime_req   <= 1'b0;
         nickel_req <= 1'b0;
         penny_req  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fault      <= 1'b0;
         remaining  <= '0;
         coins_out  <= '0;
      end else begin
         state      <= state_nxt;
         vend_q     <= vend;
         cnt        <= cnt_nxt;
         dime_req   <= dime_nxt;
         nickel_req <= nickel_nxt;
         penny_req  <= penny_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         fault      <= fault_nxt;
         remaining  <= rem_nxt;
         coins_out  <= coins_nxt;
      end
   end

   // Next-state: handshake progress, gap expiry and watchdog
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, FAULT: if (start) state_nxt = SELECT;
         SELECT:      state_nxt = (remaining == '0) ? IDLE : REQ;
         REQ: begin
            if (coin_ack)  state_nxt = RELEASE;
            else if (tmo)  state_nxt = FAULT;
         end
         RELEASE: begin
            if (!coin_ack) state_nxt = GAP;
            else if (tmo)  state_nxt = FAULT;
         end
         GAP:         if (gap_end) state_nxt = SELECT;
         default:     state_nxt = IDLE;
      endcase
   end

   // Output/datapath next values; everything holds unless a transition updates it
   always_comb begin
      dime_nxt   = dime_req;
      nickel_nxt = nickel_req;
      penny_nxt  = penny_req;
      busy_nxt   = busy;
      done_nxt   = 1'b0;
      fault_nxt  = fault;
      rem_nxt    = remaining;
      coins_nxt  = coins_out;
      // Timer restarts on every state change and only runs while waiting
      cnt_nxt    = '0;
      if (state_nxt == state && (state == REQ || state == RELEASE || state == GAP))
         cnt_nxt = cnt + CNT_W'(1);
      case (state)
         IDLE, FAULT: begin
            if (start) begin
               rem_nxt   = change;
               coins_nxt = '0;
               fault_nxt = 1'b0;
               busy_nxt  = 1'b1;
            end
         end
         SELECT: begin
            if (remaining == '0) begin
               busy_nxt = 1'b0;
               done_nxt = 1'b1;
            end else begin
               dime_nxt   = pick_dime;
               nickel_nxt = pick_nickel;
               penny_nxt  = pick_penny;
            end
         end
         REQ: begin
            if (coin_ack) begin
               dime_nxt   = 1'b0;
               nickel_nxt = 1'b0;
               penny_nxt  = 1'b0;
               rem_nxt    = remaining - coin_val;
               coins_nxt  = (coins_out == 4'hF) ? coins_out : coins_out + 4'd1;
            end else if (tmo) begin
               dime_nxt   = 1'b0;
               nickel_nxt = 1'b0;
               penny_nxt  = 1'b0;
               fault_nxt  = 1'b1;
               busy_nxt   = 1'b0;
            end
         end
         RELEASE: begin
            if (coin_ack && tmo) begin
               fault_nxt = 1'b1;
               busy_nxt  = 1'b0;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: table of payouts, hand-built corner sequences and
// random payouts against a greedy-coin arithmetic model, with a hopper model.
module tb_change_dispenser;

   localparam int AW  = 5;
   localparam int TMO = 25;
   localparam int GAP = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          vend = 1'b0;
   logic [AW-1:0] change = '0;
   logic          coin_ack;
   logic          dime_req, nickel_req, penny_req, busy, done, fault;
   logic [AW-1:0] remaining;
   logic [3:0]    coins_out;

   change_dispenser #(.AMT_W(AW), .TIMEOUT(TMO), .GAP_CYC(GAP)) dut (
      .clk(clk), .rst(rst), .vend(vend), .change(change), .coin_ack(coin_ack),
      .dime_req(dime_req), .nickel_req(nickel_req), .penny_req(penny_req),
      .busy(busy), .done(done), .fault(fault), .remaining(remaining),
      .coins_out(coins_out)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Hopper: toggles ack to follow req after hop_dly idle negedges
   bit hop_en   = 1'b0;
   bit hop_rand = 1'b0;
   int hop_dly  = 3;
   int hcnt     = 0;
   always @(negedge clk) begin
      if (!rst || !hop_en) begin
         coin_ack = 1'b0;
         hcnt     = 0;
      end else if (coin_ack == (dime_req | nickel_req | penny_req)) begin
         hcnt = 0;
      end else if (hcnt >= hop_dly) begin
         coin_ack = ~coin_ack;
         hcnt     = 0;
         if (hop_rand) hop_dly = $urandom_range(0, 5);
      end else begin
         hcnt++;
      end
   end

   // Monitor: records each requested coin and checks protocol invariants every cycle
   int       obs_q[$];
   logic [2:0] prev_req = '0;
   logic     prev_done = 1'b0;
   int       idle_run = 0;
   bit       seen_coin = 1'b0;
   always @(posedge clk) begin
      logic [2:0] cur;
      #1;
      cur = {dime_req, nickel_req, penny_req};
      check("onehot_req", int'($countones(cur) <= 1), 1);
      check("req_without_busy", int'(cur != 0 && !busy), 0);
      if (cur != 0 && prev_req == 0) begin
         obs_q.push_back(dime_req ? 10 : (nickel_req ? 5 : 1));
         if (seen_coin) check("gap_between_coins", int'(idle_run >= GAP), 1);
         seen_coin = 1'b1;
      end
      if (cur == 0) idle_run++; else idle_run = 0;
      if (!busy) seen_coin = 1'b0;
      if (done) check("done_one_cycle", int'(prev_done), 0);
      prev_req  = cur;
      prev_done = done;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic pulse_vend(input int c);
      @(negedge clk); change = AW'(c); vend = 1'b1;
      @(negedge clk); vend = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 800; i++) begin
         tick();
         if (done) begin ok = 1'b1; break; end
      end
      if (!ok) check({name, "_done_timeout"}, 0, 1);
   endtask

   // Compares the observed coin stream against d dimes, n nickels, p pennies
   task automatic check_coins(input string name, input int d, input int n, input int p);
      int exp_q[$];
      for (int i = 0; i < d; i++) exp_q.push_back(10);
      for (int i = 0; i < n; i++) exp_q.push_back(5);
      for (int i = 0; i < p; i++) exp_q.push_back(1);
      check({name, "_ncoins"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check($sformatf("%s_coin%0d", name, i), obs_q[i], exp_q[i]);
   endtask

   task automatic run_payout(input string name, input int c, input int d,
                             input int n, input int p, input int coins);
      obs_q.delete();
      pulse_vend(c);
      wait_done(name);
      check_coins(name, d, n, p);
      check({name, "_coins_out"}, int'(coins_out), coins);
      check({name, "_remaining"}, int'(remaining), 0);
      check({name, "_fault"}, int'(fault), 0);
      tick();
      check({name, "_busy_after"}, int'(busy), 0);
   endtask

   typedef struct {
      int chg;
      int nd;
      int nn;
      int np;
      int coins;
   } vec_t;

   vec_t tbl[8];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k;
      tbl[0] = '{7,  0, 1, 2, 3};
      tbl[1] = '{19, 1, 1, 4, 6};
      tbl[2] = '{0,  0, 0, 0, 0};
      tbl[3] = '{10, 1, 0, 0, 1};
      tbl[4] = '{31, 3, 0, 1, 4};
      tbl[5] = '{5,  0, 1, 0, 1};
      tbl[6] = '{14, 1, 0, 4, 5};
      tbl[7] = '{29, 2, 1, 4, 7};

      // Reset state
      #1 rst = 1'b0;
      #11;
      check("rst_dime", int'(dime_req), 0);
      check("rst_nickel", int'(nickel_req), 0);
      check("rst_penny", int'(penny_req), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_fault", int'(fault), 0);
      check("rst_remaining", int'(remaining), 0);
      check("rst_coins", int'(coins_out), 0);
      @(negedge clk); rst = 1'b1; hop_en = 1'b1; hop_dly = 3;
      tick();

      // Latency and order for change=7
      obs_q.delete();
      @(negedge clk); change = 7; vend = 1'b1;
      tick();
      check("lat_busy", int'(busy), 1);
      check("lat_no_req_yet", int'(nickel_req), 0);
      tick();
      check("lat_nickel_req", int'(nickel_req), 1);
      @(negedge clk); vend = 1'b0;
      wait_done("c7");
      check_coins("c7", 0, 1, 2);
      check("c7_coins_out", int'(coins_out), 3);
      check("c7_remaining", int'(remaining), 0);

      // Table of payouts
      for (int i = 0; i < 8; i++)
         run_payout($sformatf("tbl%0d", i), tbl[i].chg, tbl[i].nd, tbl[i].nn,
                    tbl[i].np, tbl[i].coins);

      // change=0: done one cycle after busy, no coins
      obs_q.delete();
      @(negedge clk); change = 0; vend = 1'b1;
      tick();
      check("z_busy", int'(busy), 1);
      check("z_done_early", int'(done), 0);
      @(negedge clk); vend = 1'b0;
      tick();
      check("z_done", int'(done), 1);
      check("z_busy_off", int'(busy), 0);
      tick();
      check("z_done_off", int'(done), 0);
      check("z_coins", int'(coins_out), 0);
      check("z_no_req", obs_q.size(), 0);

      // Hopper never acks: timeout fault, then recovery
      hop_en = 1'b0;
      obs_q.delete();
      @(negedge clk); change = 10; vend = 1'b1;
      tick(); tick();
      check("to_dime_req", int'(dime_req), 1);
      @(negedge clk); vend = 1'b0;
      k = 1;
      while (!fault && k < TMO + 10) begin tick(); k++; end
      check("to_cycles_in_window", int'(k >= TMO && k <= TMO + 1), 1);
      check("to_fault", int'(fault), 1);
      check("to_dime_off", int'(dime_req), 0);
      check("to_remaining", int'(remaining), 10);
      check("to_busy", int'(busy), 0);
      check("to_coins", int'(coins_out), 0);
      repeat (3) tick();
      check("to_fault_sticky", int'(fault), 1);
      hop_en = 1'b1;
      obs_q.delete();
      @(negedge clk); change = 5; vend = 1'b1;
      tick();
      check("rec_fault_clr", int'(fault), 0);
      check("rec_busy", int'(busy), 1);
      @(negedge clk); vend = 1'b0;
      wait_done("rec");
      check_coins("rec", 0, 1, 0);
      check("rec_coins_out", int'(coins_out), 1);

      // Reset mid-REQ with vend held high across release
      hop_en = 1'b0;
      @(negedge clk); change = 10; vend = 1'b1;
      tick(); tick();
      check("mr_in_req", int'(dime_req), 1);
      @(negedge clk); rst = 1'b0;
      #1;
      check("mr_dime", int'(dime_req), 0);
      check("mr_busy", int'(busy), 0);
      check("mr_remaining", int'(remaining), 0);
      check("mr_coins", int'(coins_out), 0);
      check("mr_fault", int'(fault), 0);
      check("mr_done", int'(done), 0);
      tick();
      @(negedge clk); rst = 1'b1; hop_en = 1'b1; obs_q.delete();
      repeat (8) tick();
      check("mr_no_payout_busy", int'(busy), 0);
      check("mr_no_payout_req", obs_q.size(), 0);
      @(negedge clk); vend = 1'b0;
      run_payout("mr_toggle", 5, 0, 1, 0, 1);

      // Extra vend edge with different change while busy is ignored
      obs_q.delete();
      pulse_vend(15);
      repeat (6) tick();
      pulse_vend(3);
      wait_done("busy_edge");
      check_coins("busy_edge", 1, 1, 0);
      check("busy_edge_coins", int'(coins_out), 2);
      check("busy_edge_remaining", int'(remaining), 0);

      // Random payouts, random hopper delays, greedy arithmetic model
      hop_rand = 1'b1;
      for (int i = 0; i < 20; i++) begin
         int c;
         c = $urandom_range(0, 31);
         run_payout($sformatf("rnd%0d_c%0d", i, c), c, c / 10, (c % 10) / 5, c % 5,
                    c / 10 + (c % 10) / 5 + c % 5);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
